// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage 32-bit access sequencer for a 16-bit async SRAM
// Each access runs as two halfword phases (LO then HI) of WAIT_CYCLES cycles, then one DONE cycle.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] haddr_q;
  logic [31:0]        wdata_q;
  logic               is_write_q;
  logic [31:0]        rdata_q;

  logic req, last, active, half;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[31:SRAM_AW+1], addr[1:0]};

  assign req    = mem_read | mem_write;
  assign last   = (cnt_q == CNT_LAST);
  assign active = (state_q == LO) || (state_q == HI);
  assign half   = (state_q == HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      haddr_q    <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // A simultaneous read and write request resolves to a write.
      if (state_q == IDLE && req) begin
        haddr_q    <= addr[SRAM_AW:2];
        wdata_q    <= wdata;
        is_write_q <= mem_write;
      end
      if (!is_write_q && last) begin
        if (state_q == LO) rdata_q[15:0]  <= sram_dq_i;
        if (state_q == HI) rdata_q[31:16] <= sram_dq_i;
      end
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign sram_addr  = active ? {haddr_q, half} : '0;
  assign sram_dq_o  = active ? (half ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0000;
  assign sram_ce_n  = !active;
  assign sram_oe_n  = !(active && !is_write_q);
  assign sram_dq_oe = active && is_write_q;
  // The final wait cycle of a write phase keeps data driven with we_n high (hold time).
  assign sram_we_n  = !(active && is_write_q && !last);

endmodule
